// File: rtl/gamepad_pmod_tx_if.sv
// Gamepad Pmod serial link lines: data, shift clock and latch strobe.
interface gamepad_pmod_tx_if;
    logic pmod_data;
    logic pmod_clk;
    logic pmod_latch;

    modport master (output pmod_data, output pmod_clk, output pmod_latch);
    modport slave  (input  pmod_data, input  pmod_clk, input  pmod_latch);
endinterface

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: shifts a snapshot of NUM_PADS x 12 button bits MSB first,
// then pulses latch and idles for FRAME_GAP cycles before the next frame.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | all lines low, waiting for enable
//  S_SHIFT | serialising the snapshot word, CLK_DIV-cycle clock half-periods
//  S_LATCH | latch strobe high for CLK_DIV cycles, frame_done on the last one
//  S_GAP   | all lines low for FRAME_GAP cycles, then restart or go idle
module gamepad_pmod_tx #(
    parameter int CLK_DIV   = 4,
    parameter int FRAME_GAP = 64,
    parameter int NUM_PADS  = 1,
    localparam int NB       = 12 * NUM_PADS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NB-1:0]           buttons,
    input  logic [NUM_PADS-1:0]     present,
    gamepad_pmod_tx_if.master       pmod,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NB + 1);
    localparam int GW = $clog2(FRAME_GAP + 1);

    localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_ONE    = HW'(1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(NB - 1);
    localparam logic [BW-1:0] BIT_ONE     = BW'(1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(FRAME_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE     = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic            phase_q, phase_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NB-1:0]   word_q, word_d;
    logic            data_q, data_d;
    logic            pclk_q, pclk_d;
    logic            latch_q, latch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NB-1:0]   snap;

    // Absent pads read as all-ones, matching an unplugged controller.
    always_comb begin
        snap = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            snap[12*p +: 12] = present[p] ? buttons[12*p +: 12] : 12'hFFF;
        end
    end

    // Next-state logic; outputs are derived from the next state so they come out registered.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SHIFT;
                    word_d  = snap;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    half_d  = HALF_RELOAD;
                end
            end
            S_SHIFT: begin
                if (half_q != '0) begin
                    half_d = half_q - HALF_ONE;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    half_d  = HALF_RELOAD;
                end else if (bit_q == BIT_LAST) begin
                    state_d = S_LATCH;
                    phase_d = 1'b0;
                    half_d  = HALF_RELOAD;
                end else begin
                    // Next bit moves into the MSB as the clock drops low.
                    bit_d   = bit_q + BIT_ONE;
                    phase_d = 1'b0;
                    half_d  = HALF_RELOAD;
                    word_d  = {word_q[NB-2:0], 1'b0};
                end
            end
            S_LATCH: begin
                if (half_q != '0) begin
                    half_d = half_q - HALF_ONE;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GAP_RELOAD;
                end
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_ONE;
                end else if (enable) begin
                    state_d = S_SHIFT;
                    word_d  = snap;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    half_d  = HALF_RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        data_d  = (state_d == S_SHIFT) && word_d[NB-1];
        pclk_d  = (state_d == S_SHIFT) && phase_d;
        latch_d = (state_d == S_LATCH);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_LATCH) && (half_d == '0);
    end

    // State, counters, snapshot and registered line drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            half_q  <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            word_q  <= '0;
            data_q  <= 1'b0;
            pclk_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            data_q  <= data_d;
            pclk_q  <= pclk_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pmod.pmod_data  = data_q;
    assign pmod.pmod_clk   = pclk_q;
    assign pmod.pmod_latch = latch_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: one single-pad and one dual-pad instance, each watched by a
// line monitor that rebuilds the frame word from rising pmod_clk edges.
module tb_gamepad_pmod_tx;

    localparam int CD  = 2;
    localparam int GAP = 8;
    localparam int PER1 = 2*CD*12 + CD + GAP;
    localparam int PER2 = 2*CD*24 + CD + GAP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en1, en2;
    logic [11:0] btn1;
    logic [0:0]  pres1;
    logic [23:0] btn2;
    logic [1:0]  pres2;
    logic        busy1, busy2, done1, done2;

    gamepad_pmod_tx_if if1 ();
    gamepad_pmod_tx_if if2 ();

    gamepad_pmod_tx #(.CLK_DIV(CD), .FRAME_GAP(GAP), .NUM_PADS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .buttons(btn1), .present(pres1),
        .pmod(if1.master), .busy(busy1), .frame_done(done1));

    gamepad_pmod_tx #(.CLK_DIV(CD), .FRAME_GAP(GAP), .NUM_PADS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .buttons(btn2), .present(pres2),
        .pmod(if2.master), .busy(busy2), .frame_done(done2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Monitor state: captured word, bit count, latch-high cycles, done pulses, protocol errors.
    logic [23:0] cap1, cap2;
    int nbits1, nbits2, nlatch1, nlatch2, ndone1, ndone2, perr1, perr2;
    logic pclk_prev1 = 1'b0, pclk_prev2 = 1'b0, data_prev1 = 1'b0, data_prev2 = 1'b0;
    int dcyc1[$];
    int dcyc2[$];

    always @(negedge clk) begin
        if (if1.pmod_clk && !pclk_prev1) begin
            cap1 = {cap1[22:0], if1.pmod_data};
            nbits1++;
        end
        if (if1.pmod_clk && pclk_prev1 && (if1.pmod_data != data_prev1)) perr1++;
        if (if1.pmod_latch && (if1.pmod_clk || if1.pmod_data)) perr1++;
        if (if1.pmod_latch) nlatch1++;
        if (done1) begin ndone1++; dcyc1.push_back(cyc); end
        pclk_prev1 = if1.pmod_clk;
        data_prev1 = if1.pmod_data;

        if (if2.pmod_clk && !pclk_prev2) begin
            cap2 = {cap2[22:0], if2.pmod_data};
            nbits2++;
        end
        if (if2.pmod_clk && pclk_prev2 && (if2.pmod_data != data_prev2)) perr2++;
        if (if2.pmod_latch && (if2.pmod_clk || if2.pmod_data)) perr2++;
        if (if2.pmod_latch) nlatch2++;
        if (done2) begin ndone2++; dcyc2.push_back(cyc); end
        pclk_prev2 = if2.pmod_clk;
        data_prev2 = if2.pmod_data;
    end

    task automatic clear_mon();
        cap1 = '0; cap2 = '0;
        nbits1 = 0; nbits2 = 0; nlatch1 = 0; nlatch2 = 0;
        ndone1 = 0; ndone2 = 0; perr1 = 0; perr2 = 0;
        dcyc1.delete(); dcyc2.delete();
    endtask

    // Reference: the frame word is the pads concatenated high pad first, absent pads all ones.
    function automatic logic [23:0] model_word(input logic [23:0] b, input logic [1:0] p,
                                               input int np);
        logic [23:0] w;
        w = '0;
        for (int i = 0; i < np; i++) begin
            if (p[i]) w = w | (24'(b[12*i +: 12]) << (12*i));
            else      w = w | (24'hFFF << (12*i));
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (ndone1 < target && k < budget) begin tick(1); k++; end
        checks++;
        if (ndone1 < target) begin
            errors++;
            $display("FAIL %s timeout: frame_done count %0d, required %0d", name, ndone1, target);
        end
    endtask

    task automatic wait_done2(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (ndone2 < target && k < budget) begin tick(1); k++; end
        checks++;
        if (ndone2 < target) begin
            errors++;
            $display("FAIL %s timeout: frame_done count %0d, required %0d", name, ndone2, target);
        end
    endtask

    // Single-pad frame from a one-cycle enable pulse; checks word, latch width, single done.
    task automatic frame1(input logic [11:0] b, input logic p, input string name);
        logic [23:0] exp;
        btn1 = b; pres1 = p;
        exp = model_word({12'h000, b}, {1'b0, p}, 1);
        clear_mon();
        en1 = 1'b1;
        tick(1);
        en1 = 1'b0;
        wait_done1(1, 200, name);
        tick(GAP + 3);
        checks++;
        if (cap1[11:0] !== exp[11:0] || nbits1 != 12) begin
            errors++;
            $display("FAIL %s word: got %h (%0d bits), required %h (12 bits)", name, cap1[11:0], nbits1, exp[11:0]);
        end
        checks++;
        if (nlatch1 != CD || ndone1 != 1 || perr1 != 0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL %s framing: latch %0d done %0d perr %0d busy %b, required %0d 1 0 0", name, nlatch1, ndone1, perr1, busy1, CD);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en1 = 0; en2 = 0; btn1 = '0; pres1 = '0; btn2 = '0; pres2 = '0;
        clear_mon();
        tick(3);
        checks++;
        if ({if1.pmod_data, if1.pmod_clk, if1.pmod_latch, busy1, done1,
             if2.pmod_data, if2.pmod_clk, if2.pmod_latch, busy2, done2} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %b %b %b %b, required all 0", if1.pmod_data, if1.pmod_clk, if1.pmod_latch, busy1, done1);
        end
        @(negedge clk) rst_n = 1'b1;
        tick(10);
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0 || nbits1 != 0) begin
            errors++;
            $display("FAIL reset_idle: busy %b %b bits %0d, required 0 0 0", busy1, busy2, nbits1);
        end
    endtask

    task automatic test_fixed();
        btn1 = 12'hA01; pres1 = 1'b1;
        clear_mon();
        en1 = 1'b1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_pre: busy %b, required 0", busy1);
        end
        tick(1);
        en1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || if1.pmod_clk !== 1'b0 || if1.pmod_data !== 1'b1) begin
            errors++;
            $display("FAIL latency: busy %b clk %b data %b, required 1 0 1", busy1, if1.pmod_clk, if1.pmod_data);
        end
        wait_done1(1, 200, "fixed_a01");
        tick(GAP + 3);
        checks++;
        if (cap1[11:0] !== 12'hA01 || nbits1 != 12 || nlatch1 != CD || ndone1 != 1) begin
            errors++;
            $display("FAIL fixed_a01: got %h bits %0d latch %0d done %0d, required a01 12 %0d 1", cap1[11:0], nbits1, nlatch1, ndone1, CD);
        end
        tick(20);
        checks++;
        if (busy1 !== 1'b0 || ndone1 != 1) begin
            errors++;
            $display("FAIL pulse_once: busy %b done %0d, required 0 1", busy1, ndone1);
        end
    endtask

    task automatic test_absent();
        frame1(12'h5A5, 1'b0, "absent");
        frame1(12'h100, 1'b1, "start_only");
        checks++;
        if (cap1[8] !== 1'b1 || (cap1[11:0] & ~12'h100) !== 12'h000) begin
            errors++;
            $display("FAIL start_decode: got %h, required only start set", cap1[11:0]);
        end
    endtask

    task automatic test_random1();
        for (int i = 0; i < 6; i++) begin
            frame1(12'($urandom), 1'($urandom_range(0, 3) != 0), "random1");
        end
    endtask

    task automatic test_two_pads();
        logic [23:0] exp;
        btn2 = {12'h800, 12'h001}; pres2 = 2'b11;
        clear_mon();
        en2 = 1'b1; tick(1); en2 = 1'b0;
        wait_done2(1, 300, "two_pads");
        tick(GAP + 3);
        checks++;
        if (cap2 !== 24'h800001 || nbits2 != 24 || nlatch2 != CD || perr2 != 0) begin
            errors++;
            $display("FAIL two_pads: got %h bits %0d latch %0d perr %0d, required 800001 24 %0d 0", cap2, nbits2, nlatch2, perr2, CD);
        end
        for (int i = 0; i < 5; i++) begin
            btn2 = 24'($urandom); pres2 = 2'($urandom);
            exp = model_word(btn2, pres2, 2);
            clear_mon();
            en2 = 1'b1; tick(1); en2 = 1'b0;
            wait_done2(1, 300, "random2");
            tick(GAP + 3);
            checks++;
            if (cap2 !== exp || nbits2 != 24 || ndone2 != 1) begin
                errors++;
                $display("FAIL random2: got %h bits %0d done %0d, required %h 24 1", cap2, nbits2, ndone2, exp);
            end
        end
    endtask

    task automatic test_period();
        btn1 = 12'h3C3; pres1 = 1'b1; btn2 = 24'h123456; pres2 = 2'b11;
        clear_mon();
        en1 = 1'b1; en2 = 1'b1;
        wait_done1(3, 400, "period1");
        wait_done2(3, 600, "period2");
        en1 = 1'b0; en2 = 1'b0;
        checks++;
        if (dcyc1.size() < 3 || dcyc1[1] - dcyc1[0] != PER1 || dcyc1[2] - dcyc1[1] != PER1) begin
            errors++;
            $display("FAIL period1: got %0d, required %0d", (dcyc1.size() >= 2) ? dcyc1[1] - dcyc1[0] : -1, PER1);
        end
        checks++;
        if (dcyc2.size() < 3 || dcyc2[1] - dcyc2[0] != PER2 || dcyc2[2] - dcyc2[1] != PER2) begin
            errors++;
            $display("FAIL period2: got %0d, required %0d", (dcyc2.size() >= 2) ? dcyc2[1] - dcyc2[0] : -1, PER2);
        end
        tick(PER2 + 10);
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0 || perr1 != 0 || perr2 != 0) begin
            errors++;
            $display("FAIL period_stop: busy %b %b perr %0d %0d, required 0 0 0 0", busy1, busy2, perr1, perr2);
        end
    endtask

    task automatic test_enable_drop();
        btn1 = 12'h0F0; pres1 = 1'b1;
        clear_mon();
        en1 = 1'b1;
        tick(10);
        en1 = 1'b0;
        wait_done1(1, 200, "enable_drop");
        tick(GAP + 20);
        checks++;
        if (cap1[11:0] !== 12'h0F0 || nbits1 != 12 || ndone1 != 1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop: got %h bits %0d done %0d busy %b, required 0f0 12 1 0", cap1[11:0], nbits1, ndone1, busy1);
        end
    endtask

    task automatic test_midframe_change();
        logic [11:0] a, b;
        a = 12'($urandom); b = ~a;
        btn1 = a; pres1 = 1'b1;
        clear_mon();
        en1 = 1'b1;
        tick(15);
        btn1 = b;
        wait_done1(1, 200, "midframe_first");
        checks++;
        if (cap1[11:0] !== a || nbits1 != 12) begin
            errors++;
            $display("FAIL midframe_first: got %h bits %0d, required %h 12", cap1[11:0], nbits1, a);
        end
        cap1 = '0; nbits1 = 0;
        wait_done1(2, 200, "midframe_second");
        en1 = 1'b0;
        checks++;
        if (cap1[11:0] !== b || nbits1 != 12) begin
            errors++;
            $display("FAIL midframe_second: got %h bits %0d, required %h 12", cap1[11:0], nbits1, b);
        end
        tick(PER1 + 10);
    endtask

    task automatic test_reset_midframe();
        btn1 = 12'hFFF; pres1 = 1'b1;
        clear_mon();
        en1 = 1'b1;
        tick(12);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if1.pmod_data, if1.pmod_clk, if1.pmod_latch, busy1, done1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b %b %b %b %b, required all 0", if1.pmod_data, if1.pmod_clk, if1.pmod_latch, busy1, done1);
        end
        en1 = 1'b0;
        tick(2);
        @(negedge clk) rst_n = 1'b1;
        clear_mon();
        tick(40);
        checks++;
        if (busy1 !== 1'b0 || nbits1 != 0 || ndone1 != 0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy %b bits %0d done %0d, required 0 0 0", busy1, nbits1, ndone1);
        end
        frame1(12'h6B2, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_absent();
        test_random1();
        test_two_pads();
        test_period();
        test_enable_drop();
        test_midframe_change();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
